// File: rtl/nrisc_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_pkg
//   Shared definitions for the NRISC ULA and the blocks that talk to it.
//   - ULA opcode encodings (ULA_ADD .. ULA_RTL)
//   - ula_is_legal(): true for the ten opcodes the ULA implements
//   - ula_uses_incdec(): true for the opcodes where the inc/dec modifier applies
//   - arb_state_e: 2-bit state encoding of the ULA arbiter FSM
// -----------------------------------------------------------------------------
package nrisc_pkg;

  localparam logic [3:0] ULA_ADD = 4'b0000;
  localparam logic [3:0] ULA_SUB = 4'b0001;
  localparam logic [3:0] ULA_AND = 4'b0010;
  localparam logic [3:0] ULA_OR  = 4'b0011;
  localparam logic [3:0] ULA_XOR = 4'b0100;
  localparam logic [3:0] ULA_SHR = 4'b0101;
  localparam logic [3:0] ULA_SHL = 4'b0110;
  localparam logic [3:0] ULA_NOT = 4'b0111;
  localparam logic [3:0] ULA_RTR = 4'b1101;
  localparam logic [3:0] ULA_RTL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  function automatic logic ula_is_legal(input logic [3:0] op);
    case (op)
      ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_XOR,
      ULA_SHR, ULA_SHL, ULA_NOT, ULA_RTR, ULA_RTL: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic ula_uses_incdec(input logic [3:0] op);
    return (op == ULA_ADD) || (op == ULA_SUB);
  endfunction

endpackage

// File: rtl/nrisc_ula_arbiter.sv
// -----------------------------------------------------------------------------
// nrisc_ula_arbiter
//   Shares one combinational NRISC_ULA between two requesters
//   (0 = core execute, 1 = address/aux unit) with round-robin arbitration.
//   One operation is outstanding at a time: IDLE accepts, EXEC drives the ULA
//   for exactly one cycle and captures its result, RESP holds the result until
//   the granted requester consumes it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready[2]   request handshake per requester
//   req_A/req_B[2*TAM]       operands, requester i at [i*TAM +: TAM]
//   req_ctrl[8]              opcode, requester i at [i*4 +: 4]
//   req_incdec[2]            inc/dec modifier per requester
//   rsp_valid/rsp_ready[2]   response handshake per requester
//   rsp_out, rsp_flags       captured ULA result and {minus,zero,carry}
//   rsp_err                  captured opcode was illegal
//   ULA_A/B/ctrl, incdec     to NRISC_ULA (live only in EXEC)
//   ULA_OUT, ULA_flags       from NRISC_ULA
// -----------------------------------------------------------------------------
module nrisc_ula_arbiter
  import nrisc_pkg::*;
#(
  parameter int TAM = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*TAM-1:0] req_A,
  input  logic [2*TAM-1:0] req_B,
  input  logic [7:0]       req_ctrl,
  input  logic [1:0]       req_incdec,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [TAM-1:0]   rsp_out,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  output logic [TAM-1:0]   ULA_A,
  output logic [TAM-1:0]   ULA_B,
  output logic [3:0]       ULA_ctrl,
  output logic             incdec,
  input  logic [TAM-1:0]   ULA_OUT,
  input  logic [2:0]       ULA_flags
);

  arb_state_e     state_q, state_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic           grant_q, grant_d;
  logic [TAM-1:0] a_q, a_d;
  logic [TAM-1:0] b_q, b_d;
  logic [3:0]     ctrl_q, ctrl_d;
  logic           incdec_q, incdec_d;
  logic [TAM-1:0] rsp_out_q, rsp_out_d;
  logic [2:0]     rsp_flags_q, rsp_flags_d;
  logic           rsp_err_q, rsp_err_d;

  // Round-robin pick: the pointed-to requester if it is asking, else the other.
  logic winner;
  logic legal;

  assign winner = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
  assign legal  = ula_is_legal(ctrl_q);

  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    incdec_d    = incdec_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    ULA_A       = '0;
    ULA_B       = '0;
    ULA_ctrl    = ULA_ADD;
    incdec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready[winner] = 1'b1;
          grant_d  = winner;
          a_d      = winner ? req_A[2*TAM-1:TAM] : req_A[TAM-1:0];
          b_d      = winner ? req_B[2*TAM-1:TAM] : req_B[TAM-1:0];
          ctrl_d   = winner ? req_ctrl[7:4]      : req_ctrl[3:0];
          incdec_d = req_incdec[winner];
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Illegal opcodes leave the ULA at add 0+0 and report an error
        // instead of whatever the ULA would produce for them.
        if (legal) begin
          ULA_A    = a_q;
          ULA_B    = b_q;
          ULA_ctrl = ctrl_q;
          incdec   = incdec_q & ula_uses_incdec(ctrl_q);
        end
        rsp_out_d   = legal ? ULA_OUT   : '0;
        rsp_flags_d = legal ? ULA_flags : 3'b000;
        rsp_err_d   = ~legal;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          rr_ptr_d = ~grant_q;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      grant_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= ULA_ADD;
      incdec_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_flags_q <= 3'b000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      incdec_q    <= incdec_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_out   = rsp_out_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

endmodule
